// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_pkg
// Description : Shared register-file constants for the write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wr_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

endpackage : regfile_wr_arbiter_pkg
`default_nettype wire

// File: rtl/wb_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_buffer
// Description : One-entry valid/ready holding register for long-unit results.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_buffer
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic              i_drain,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_rd,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic              w_load;

    // A drain and a refill may share one cycle, so the entry never bubbles.
    assign o_ready = !r_valid || i_drain;
    // Results aimed at x0 are accepted but never stored.
    assign w_load  = i_valid && o_ready && (i_rd != ADDR_W'(REG_X0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_rd    <= i_rd;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_rd    = r_rd;
    assign o_data  = r_data;

endmodule : wb_result_buffer
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Shares the register-file write port between WB and the long
//               unit; tracks pending long-unit destinations for ID stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int XLEN       = regfile_wr_arbiter_pkg::XLEN,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_wr,
    input  logic              pipe_wr_en,
    input  logic [ADDR_W-1:0] pipe_wr_addr,
    input  logic [XLEN-1:0]   pipe_wr_data,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    output logic              lu_ready,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]   rf_wr_data,
    output logic              pipe_hold,
    output logic              sb_stall,
    output logic              sb_busy
);

    localparam int                 c_NREGS      = 2 ** ADDR_W;
    localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_LIM = c_CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0]  c_X0         = ADDR_W'(REG_X0);

    logic [c_NREGS-1:0] r_pending;
    logic [c_NREGS-1:0] w_pending_nxt;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_buf_ready;
    logic               w_buf_valid;
    logic [ADDR_W-1:0]  w_buf_rd;
    logic [XLEN-1:0]    w_buf_data;
    logic               w_pipe_req;
    logic               w_lu_win;
    logic               w_hit;
    logic               w_issue;

    wb_result_buffer #(
        .DATA_W (XLEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (lu_valid),
        .i_rd    (lu_rd),
        .i_data  (lu_data),
        .o_ready (w_buf_ready),
        .i_drain (w_lu_win),
        .o_valid (w_buf_valid),
        .o_rd    (w_buf_rd),
        .o_data  (w_buf_data)
    );

    assign w_pipe_req = pipe_wr_en && (pipe_wr_addr != c_X0);
    assign w_lu_win   = w_buf_valid && (!w_pipe_req || (r_starve_cnt == c_STARVE_LIM));

    // The buffered entry still holds its pending bit during its own write
    // cycle, so the stall stays up one cycle longer than strictly needed.
    assign w_hit = (id_rs1_used && (id_rs1 != c_X0) && r_pending[id_rs1]) ||
                   (id_rs2_used && (id_rs2 != c_X0) && r_pending[id_rs2]) ||
                   (id_wr       && (id_rd  != c_X0) && r_pending[id_rd]);
    assign w_issue = issue_valid && !w_hit && (issue_rd != c_X0);

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_lu_win) begin
            w_pending_nxt[w_buf_rd] = 1'b0;
        end
        if (w_issue) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_lu_win) begin
                r_starve_cnt <= '0;
            end else if (w_buf_valid && w_pipe_req && (r_starve_cnt != c_STARVE_LIM)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign rf_wr_en   = rst && (w_lu_win || pipe_wr_en);
    assign rf_wr_addr = w_lu_win ? w_buf_rd   : pipe_wr_addr;
    assign rf_wr_data = w_lu_win ? w_buf_data : pipe_wr_data;
    assign pipe_hold  = rst && w_lu_win && w_pipe_req;
    assign lu_ready   = rst && w_buf_ready;
    assign sb_stall   = rst && w_hit;
    assign sb_busy    = rst && ((|r_pending) || w_buf_valid);

endmodule : regfile_wr_arbiter
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a behavioural model of the write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, id_rs1_used, id_rs2_used, id_wr;
    logic [4:0]  issue_rd, id_rs1, id_rs2, id_rd;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [31:0] pipe_wr_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready, rf_wr_en, pipe_hold, sb_stall, sb_busy;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    int n_pass  = 0;
    int n_total = 0;

    regfile_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wr(id_wr),
        .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pipe_hold(pipe_hold), .sb_stall(sb_stall), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: set of pending registers, at most one queued result,
    // and the number of consecutive cycles that result has lost to WB.
    bit         mpend [32];
    bit         mbuf_v;
    logic [4:0] mbuf_rd;
    logic [31:0] mbuf_d;
    int         mlost;
    bit         cmp_en = 1'b0;
    bit         m_ready_neg;

    function automatic bit f_preq();
        return pipe_wr_en && (pipe_wr_addr != 5'd0);
    endfunction

    function automatic bit f_luw();
        return mbuf_v && (!f_preq() || (mlost >= STARVE_MAX));
    endfunction

    function automatic bit f_stall();
        return (id_rs1_used && id_rs1 != 0 && mpend[id_rs1]) ||
               (id_rs2_used && id_rs2 != 0 && mpend[id_rs2]) ||
               (id_wr       && id_rd  != 0 && mpend[id_rd]);
    endfunction

    function automatic bit f_any_pending();
        for (int i = 0; i < 32; i++) if (mpend[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
            mbuf_v = 1'b0;
            mlost  = 0;
        end else begin
            bit luw, rdy, st;
            luw = f_luw();
            rdy = !mbuf_v || luw;
            st  = f_stall();
            if (luw) begin
                mpend[mbuf_rd] = 1'b0;
                mlost  = 0;
                mbuf_v = 1'b0;
            end else if (mbuf_v && f_preq()) begin
                mlost = (mlost < STARVE_MAX) ? mlost + 1 : STARVE_MAX;
            end
            if (lu_valid && rdy && lu_rd != 0) begin
                mbuf_v  = 1'b1;
                mbuf_rd = lu_rd;
                mbuf_d  = lu_data;
            end
            if (issue_valid && !st && issue_rd != 0) mpend[issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit luw, en;
            if (!rst) begin
                check1("rst rf_wr_en", rf_wr_en, 1'b0);
                check1("rst lu_ready", lu_ready, 1'b0);
                check1("rst pipe_hold", pipe_hold, 1'b0);
                check1("rst sb_stall", sb_stall, 1'b0);
                check1("rst sb_busy", sb_busy, 1'b0);
                m_ready_neg = 1'b0;
            end else begin
                luw = f_luw();
                en  = luw || pipe_wr_en;
                m_ready_neg = !mbuf_v || luw;
                check1("model rf_wr_en", rf_wr_en, en);
                if (en) begin
                    checkw("model rf_wr_addr", 32'(rf_wr_addr), luw ? 32'(mbuf_rd) : 32'(pipe_wr_addr));
                    checkw("model rf_wr_data", rf_wr_data, luw ? mbuf_d : pipe_wr_data);
                end
                check1("model pipe_hold", pipe_hold, luw && f_preq());
                check1("model lu_ready", lu_ready, m_ready_neg);
                check1("model sb_stall", sb_stall, f_stall());
                check1("model sb_busy", sb_busy, f_any_pending() || mbuf_v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1; issue_rd = rd; id_rd = rd; id_wr = 1'b1;
        step();
        issue_valid = 1'b0; id_wr = 1'b0;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0;
        id_rs2_used = 0; id_rd = 0; id_wr = 0; pipe_wr_en = 0; pipe_wr_addr = 0;
        pipe_wr_data = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
    endtask

    int lq[$];

    initial begin
        rst = 1'b0;
        idle_inputs();
        pipe_wr_en = 1; pipe_wr_addr = 5'd3; lu_valid = 1; lu_rd = 5'd4;
        #3;
        check1("reset rf_wr_en", rf_wr_en, 1'b0);
        check1("reset lu_ready", lu_ready, 1'b0);
        check1("reset sb_busy", sb_busy, 1'b0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        step();
        cmp_en = 1'b1;

        // RAW on a pending long-unit destination
        issue(5'd5);
        id_rs1 = 5'd5; id_rs1_used = 1;
        #3 check1("raw stall up", sb_stall, 1'b1);
        check1("raw busy", sb_busy, 1'b1);
        step();
        lu_valid = 1; lu_rd = 5'd5; lu_data = 32'h1234_5678;
        #3 check1("raw lu_ready", lu_ready, 1'b1);
        step();
        lu_valid = 0;
        #3 check1("raw write en", rf_wr_en, 1'b1);
        checkw("raw write addr", 32'(rf_wr_addr), 32'd5);
        check1("raw stall in write cycle", sb_stall, 1'b1);
        step();
        #3 check1("raw stall released", sb_stall, 1'b0);
        id_rs1_used = 0;

        // Simple result with idle pipe
        issue(5'd7);
        lu_valid = 1; lu_rd = 5'd7; lu_data = 32'hDEADBEEF;
        step();
        lu_valid = 0;
        #3 check1("x7 write en", rf_wr_en, 1'b1);
        checkw("x7 write addr", 32'(rf_wr_addr), 32'd7);
        checkw("x7 write data", rf_wr_data, 32'hDEADBEEF);
        step();
        #3 check1("x7 busy cleared", sb_busy, 1'b0);

        // Starvation: WB wins three cycles, then the long unit is forced through
        issue(5'd10);
        lu_valid = 1; lu_rd = 5'd10; lu_data = 32'h0000_AAAA;
        step();
        lu_valid = 0; pipe_wr_en = 1; pipe_wr_addr = 5'd12; pipe_wr_data = 32'h111;
        for (int i = 0; i < 3; i++) begin
            #3 checkw("starve pipe wins addr", 32'(rf_wr_addr), 32'd12);
            check1("starve no hold", pipe_hold, 1'b0);
            check1("starve lu_ready low", lu_ready, 1'b0);
            step();
        end
        #3 checkw("starve lu wins addr", 32'(rf_wr_addr), 32'd10);
        checkw("starve lu wins data", rf_wr_data, 32'h0000_AAAA);
        check1("starve hold", pipe_hold, 1'b1);
        step();
        #3 checkw("starve after addr", 32'(rf_wr_addr), 32'd12);
        check1("starve after hold", pipe_hold, 1'b0);
        pipe_wr_en = 0;

        // WB write to x0 is not a request; x0 results are dropped
        issue(5'd11);
        lu_valid = 1; lu_rd = 5'd11; lu_data = 32'h0B0B;
        step();
        pipe_wr_en = 1; pipe_wr_addr = 5'd0; pipe_wr_data = 32'h5;
        lu_valid = 1; lu_rd = 5'd0; lu_data = 32'hFFFF;
        #3 checkw("x0 lu wins addr", 32'(rf_wr_addr), 32'd11);
        check1("x0 no hold", pipe_hold, 1'b0);
        check1("x0 lu_ready", lu_ready, 1'b1);
        step();
        pipe_wr_en = 0; lu_valid = 0;
        #3 check1("x0 result not written", rf_wr_en, 1'b0);
        check1("x0 busy cleared", sb_busy, 1'b0);

        // Back-to-back results
        issue(5'd3);
        issue(5'd4);
        lu_valid = 1; lu_rd = 5'd3; lu_data = 32'h3;
        #3 check1("b2b ready 1", lu_ready, 1'b1);
        step();
        lu_rd = 5'd4; lu_data = 32'h4;
        #3 check1("b2b ready 2", lu_ready, 1'b1);
        checkw("b2b first addr", 32'(rf_wr_addr), 32'd3);
        step();
        lu_valid = 0;
        #3 check1("b2b second en", rf_wr_en, 1'b1);
        checkw("b2b second addr", 32'(rf_wr_addr), 32'd4);
        step();
        #3 check1("b2b busy cleared", sb_busy, 1'b0);

        // Asynchronous reset with pending x9 and a full buffer
        issue(5'd9);
        issue(5'd14);
        lu_valid = 1; lu_rd = 5'd14; lu_data = 32'hE;
        step();
        lu_valid = 0; pipe_wr_en = 1; pipe_wr_addr = 5'd2; pipe_wr_data = 32'h22;
        id_rs1 = 5'd9; id_rs1_used = 1;
        #1 rst = 1'b0;
        #1 check1("async rf_wr_en", rf_wr_en, 1'b0);
        check1("async lu_ready", lu_ready, 1'b0);
        check1("async pipe_hold", pipe_hold, 1'b0);
        check1("async sb_stall", sb_stall, 1'b0);
        check1("async sb_busy", sb_busy, 1'b0);
        pipe_wr_en = 0;
        step();
        #1 rst = 1'b1;
        #1 check1("post-reset busy", sb_busy, 1'b0);
        check1("post-reset x9 no stall", sb_stall, 1'b0);
        idle_inputs();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            if (lu_valid && m_ready_neg) lu_valid = 0;
            if (!lu_valid && $urandom_range(0, 2) == 0) begin
                if (lq.size() > 0 && $urandom_range(0, 7) != 0) begin
                    lu_valid = 1; lu_rd = 5'(lq.pop_front()); lu_data = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    lu_valid = 1; lu_rd = 5'd0; lu_data = $urandom;
                end
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom);
            id_rd       = issue_valid ? issue_rd : 5'($urandom);
            id_wr       = issue_valid || ($urandom_range(0, 1) == 1);
            id_rs1      = 5'($urandom); id_rs1_used = ($urandom_range(0, 1) == 1);
            id_rs2      = 5'($urandom); id_rs2_used = ($urandom_range(0, 1) == 1);
            pipe_wr_en  = ($urandom_range(0, 1) == 1);
            pipe_wr_addr = 5'($urandom);
            pipe_wr_data = $urandom;
            if (issue_valid && !f_stall() && issue_rd != 0) lq.push_back(int'(issue_rd));
        end
        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter
`default_nettype wire
